pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot/run/halt control, branch/call/return redirects,
// exception entry and a circular return-address stack.
module pc_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int INC_STEP  = 1,
  parameter int RESET_VEC = 0,
  parameter int EXC_VEC   = 'h100,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_ready,
  input  logic              branch_true,
  input  logic              call_true,
  input  logic              ret_true,
  input  logic [ADDR_W-1:0] new_addr,
  input  logic              exc_req,
  input  logic              halt_req,
  input  logic              resume_req,
  output logic [ADDR_W-1:0] pc_output,
  output logic              pc_valid,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [ADDR_W-1:0] INC      = ADDR_W'(INC_STEP);
  localparam logic [ADDR_W-1:0] EXC_ADDR = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RESET_VEC);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              underflow_reg, underflow_next;
  logic              push_en;
  logic [PTR_W-1:0]  push_idx;
  logic [ADDR_W-1:0] link_addr;

  // ptr_reg addresses the top entry; pushing into ptr+1 when full lands on the oldest slot
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  assign link_addr = pc_reg + INC;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    ptr_next       = ptr_reg;
    count_next     = count_reg;
    underflow_next = 1'b0;
    push_en        = 1'b0;
    push_idx       = ptr_reg + PTR_ONE;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        if (exc_req) begin
          pc_next    = EXC_ADDR;
          count_next = '0;
        end else if (halt_req) begin
          state_next = HALT;
        end else if (call_true && ret_true) begin
          pc_next = new_addr;
          push_en = 1'b1;
          if (count_reg == '0) begin
            ptr_next   = ptr_reg + PTR_ONE;
            count_next = CNT_W'(1);
          end else begin
            push_idx = ptr_reg;
          end
        end else if (call_true) begin
          pc_next  = new_addr;
          push_en  = 1'b1;
          ptr_next = ptr_reg + PTR_ONE;
          if (count_reg != CNT_MAX) count_next = count_reg + CNT_W'(1);
        end else if (ret_true) begin
          if (count_reg != '0) begin
            pc_next    = ras_mem[ptr_reg];
            ptr_next   = ptr_reg - PTR_ONE;
            count_next = count_reg - CNT_W'(1);
          end else begin
            pc_next        = new_addr;
            underflow_next = 1'b1;
          end
        end else if (branch_true) begin
          pc_next = new_addr;
        end else if (fetch_ready) begin
          pc_next = pc_reg + INC;
        end
      end
      HALT: begin
        if (exc_req) begin
          pc_next    = EXC_ADDR;
          count_next = '0;
          state_next = RUN;
        end else if (resume_req) begin
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= BOOT;
      pc_reg        <= RST_ADDR;
      ptr_reg       <= '0;
      count_reg     <= '0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      ptr_reg       <= ptr_next;
      count_reg     <= count_next;
      underflow_reg <= underflow_next;
    end
  end

  // Stack storage needs no reset: a zero count hides whatever it holds
  always_ff @(posedge clk) begin
    if (push_en) ras_mem[push_idx] <= link_addr;
  end

  assign pc_output     = pc_reg;
  assign pc_valid      = (state_reg == RUN);
  assign ras_empty     = (count_reg == '0);
  assign ras_full      = (count_reg == CNT_MAX);
  assign ras_underflow = underflow_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit instance for sequencing/RAS/exception
// behaviour and an 8-bit instance for address wrap-around.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready, branch_true, call_true, ret_true;
  logic        exc_req, halt_req, resume_req;
  logic [31:0] new_addr;
  logic [31:0] pc_output;
  logic        pc_valid, ras_empty, ras_full, ras_underflow;

  logic [7:0]  pc8;
  logic        valid8, empty8, full8, uflow8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(32), .INC_STEP(1), .RESET_VEC(0), .EXC_VEC('h100), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .branch_true(branch_true),
    .call_true(call_true), .ret_true(ret_true), .new_addr(new_addr), .exc_req(exc_req),
    .halt_req(halt_req), .resume_req(resume_req), .pc_output(pc_output), .pc_valid(pc_valid),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  pc_sequencer #(.ADDR_W(8), .INC_STEP(1), .RESET_VEC('hFD), .EXC_VEC('h10), .RAS_DEPTH(2)) dut8 (
    .clk(clk), .rst(rst), .fetch_ready(1'b1), .branch_true(1'b0),
    .call_true(1'b0), .ret_true(1'b0), .new_addr(8'h00), .exc_req(1'b0),
    .halt_req(1'b0), .resume_req(1'b0), .pc_output(pc8), .pc_valid(valid8),
    .ras_empty(empty8), .ras_full(full8), .ras_underflow(uflow8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl;
    branch_true = 0; call_true = 0; ret_true = 0;
    exc_req = 0; halt_req = 0; resume_req = 0;
  endtask

  initial begin
    logic [31:0] links [4];
    rst = 1; fetch_ready = 1; new_addr = 0;
    clear_ctl();
    #3;
    check("rst_pc", pc_output, 32'h0);
    check("rst_valid", {31'b0, pc_valid}, 32'h0);
    check("rst_empty", {31'b0, ras_empty}, 32'h1);
    check("rst_full", {31'b0, ras_full}, 32'h0);
    check("rst_uflow", {31'b0, ras_underflow}, 32'h0);

    step();
    rst = 0;
    #1;
    check("boot_valid", {31'b0, pc_valid}, 32'h0);
    step();
    check("run_valid", {31'b0, pc_valid}, 32'h1);
    check("seq_pc0", pc_output, 32'h0);
    check("w8_fd", {24'b0, pc8}, 32'hFD);
    step(); check("seq_pc1", pc_output, 32'h1); check("w8_fe", {24'b0, pc8}, 32'hFE);
    step(); check("seq_pc2", pc_output, 32'h2); check("w8_ff", {24'b0, pc8}, 32'hFF);
    step(); check("seq_pc3", pc_output, 32'h3); check("w8_wrap", {24'b0, pc8}, 32'h00);
    step(); step();
    check("seq_pc5", pc_output, 32'h5);

    // stall then branch during stall
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", pc_output, 32'h5);
    end
    branch_true = 1; new_addr = 32'h40;
    step(); check("branch_stall", pc_output, 32'h40);
    new_addr = 32'h10;
    step(); check("branch_10", pc_output, 32'h10);
    branch_true = 0;

    // call then return
    call_true = 1; new_addr = 32'h80;
    step(); check("call_pc", pc_output, 32'h80);
    check("call_nonempty", {31'b0, ras_empty}, 32'h0);
    call_true = 0; ret_true = 1; new_addr = 32'hDEAD;
    step(); check("ret_pc", pc_output, 32'h11);
    check("ret_empty", {31'b0, ras_empty}, 32'h1);
    ret_true = 0;

    // five calls into a 4-deep stack; the first link (0x12) is overwritten
    links[0] = 32'h201; links[1] = 32'h211; links[2] = 32'h221; links[3] = 32'h231;
    call_true = 1;
    for (int i = 0; i < 5; i++) begin
      new_addr = 32'h200 + 32'(i) * 32'h10;
      step();
      check("callN_pc", pc_output, 32'h200 + 32'(i) * 32'h10);
      if (i >= 3) check("callN_full", {31'b0, ras_full}, 32'h1);
    end
    call_true = 0; ret_true = 1; new_addr = 32'h999;
    for (int i = 3; i >= 0; i--) begin
      step();
      check("retN_pc", pc_output, links[i]);
      check("retN_uflow", {31'b0, ras_underflow}, 32'h0);
    end
    check("retN_empty", {31'b0, ras_empty}, 32'h1);
    new_addr = 32'h300;
    step();
    check("uflow_pc", pc_output, 32'h300);
    check("uflow_pulse", {31'b0, ras_underflow}, 32'h1);
    check("uflow_empty", {31'b0, ras_empty}, 32'h1);
    ret_true = 0;
    step();
    check("uflow_clear", {31'b0, ras_underflow}, 32'h0);

    // exception beats halt and return, and flushes the stack
    call_true = 1; new_addr = 32'h500;
    step(); check("pre_exc_call", pc_output, 32'h500);
    call_true = 0; exc_req = 1; ret_true = 1; halt_req = 1;
    step();
    check("exc_pc", pc_output, 32'h100);
    check("exc_empty", {31'b0, ras_empty}, 32'h1);
    check("exc_run", {31'b0, pc_valid}, 32'h1);
    clear_ctl();

    // halt, ignored inputs, resume
    fetch_ready = 1; halt_req = 1;
    step();
    check("halt_valid", {31'b0, pc_valid}, 32'h0);
    check("halt_pc", pc_output, 32'h100);
    halt_req = 0; branch_true = 1; new_addr = 32'h777;
    step(); check("halt_ignore", pc_output, 32'h100);
    branch_true = 0; resume_req = 1;
    step();
    check("resume_valid", {31'b0, pc_valid}, 32'h1);
    check("resume_pc", pc_output, 32'h100);
    resume_req = 0;
    step(); check("resume_inc", pc_output, 32'h101);

    // tail-call replaces the top link
    call_true = 1; new_addr = 32'h600;
    step(); check("tc_call", pc_output, 32'h600);
    ret_true = 1; new_addr = 32'h700;
    step(); check("tc_pc", pc_output, 32'h700);
    call_true = 0; new_addr = 32'h0;
    step(); check("tc_ret", pc_output, 32'h601);
    check("tc_empty", {31'b0, ras_empty}, 32'h1);
    ret_true = 0;

    // asynchronous reset mid-sequence
    step(); step();
    #2 rst = 1;
    #1;
    check("arst_pc", pc_output, 32'h0);
    check("arst_valid", {31'b0, pc_valid}, 32'h0);
    check("arst_pc8", {24'b0, pc8}, 32'hFD);
    step();
    rst = 0;
    step(); step();
    check("post_rst_pc", pc_output, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
